uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart_tx: buffers writes and hands bytes to the transmitter
// one at a time using a start pulse and the transmitter's busy handshake.
module uart_tx_fifo #(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data_i,
  input  logic          wr_en_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o,
  output logic [7:0]    tx_data_o,
  output logic          tx_enable_o,
  input  logic          tx_busy_i
);

  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [7:0]    r_tx_data;
  logic          r_tx_enable;
  state_t        r_state;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_drop;
  logic w_pop;

  // Fullness comes from the registered count, so a write that arrives while
  // full is dropped even when a pop frees a slot on the same edge.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_push  = wr_en_i && !w_full;
  assign w_drop  = wr_en_i && w_full;
  assign w_pop   = (r_state == IDLE) && !w_empty && !tx_busy_i;

  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;
  assign tx_data_o   = r_tx_data;
  assign tx_enable_o = r_tx_enable;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // A byte is only popped from IDLE, so at most one byte is ever with the
  // transmitter; WAIT_BUSY waits for it to accept, WAIT_DONE for it to finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rd_ptr    <= '0;
      r_tx_data   <= 8'h00;
      r_tx_enable <= 1'b0;
    end else begin
      r_tx_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data   <= r_mem[r_rd_ptr];
            r_rd_ptr    <= r_rd_ptr + PTR_ONE;
            r_tx_enable <= 1'b1;
            r_state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy_i) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
